// File: rtl/priority_pkt_arbiter.sv
// Packet-granular strict-priority arbiter with an age-based anti-starvation guard.
// Merges the scheduler's priority queues into one TX stream and counts forwarded packets per queue.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no packet in flight; decides the next grant (one bubble cycle)
// FORWARD | passes the granted queue through until its tlast beat transfers
module priority_pkt_arbiter #(
  parameter int IF_COUNT_DOWN_RX = 3,
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int AGE_WIDTH        = 8,
  parameter int GRANT_WIDTH      = $clog2(IF_COUNT_DOWN_RX)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [IF_COUNT_DOWN_RX*AXIS_DATA_WIDTH-1:0] s_axis_arb_tdata,
  input  logic [IF_COUNT_DOWN_RX*AXIS_KEEP_WIDTH-1:0] s_axis_arb_tkeep,
  input  logic [IF_COUNT_DOWN_RX-1:0]                 s_axis_arb_tvalid,
  output logic [IF_COUNT_DOWN_RX-1:0]                 s_axis_arb_tready,
  input  logic [IF_COUNT_DOWN_RX-1:0]                 s_axis_arb_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]                  m_axis_arb_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                  m_axis_arb_tkeep,
  output logic                                        m_axis_arb_tvalid,
  input  logic                                        m_axis_arb_tready,
  output logic                                        m_axis_arb_tlast,
  input  logic                                        w_arb_enable,
  input  logic [AGE_WIDTH-1:0]                        w_starve_limit,
  input  logic                                        w_rst_pkt_counter,
  output logic [IF_COUNT_DOWN_RX*32-1:0]              w_pkt_counter,
  output logic [GRANT_WIDTH-1:0]                      w_grant,
  output logic                                        w_busy
);

  typedef enum logic {ST_IDLE, ST_FORWARD} state_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  state_t                 state_q, state_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [AGE_WIDTH-1:0]   age_q [IF_COUNT_DOWN_RX];
  logic [31:0]            cnt_q [IF_COUNT_DOWN_RX];

  logic                       decide;
  logic                       pkt_done;
  logic                       starve_hit;
  logic [GRANT_WIDTH-1:0]     starve_idx;
  logic [GRANT_WIDTH-1:0]     prio_idx;
  logic [AXIS_DATA_WIDTH-1:0] sel_data;
  logic [AXIS_KEEP_WIDTH-1:0] sel_keep;
  logic                       sel_valid;
  logic                       sel_last;

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    prio_idx   = '0;
    for (int i = IF_COUNT_DOWN_RX - 1; i >= 0; i--) begin
      if (s_axis_arb_tvalid[i]) begin
        prio_idx = GRANT_WIDTH'(i);
        if (w_starve_limit != '0 && age_q[i] >= w_starve_limit) begin
          starve_hit = 1'b1;
          starve_idx = GRANT_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < IF_COUNT_DOWN_RX; i++) begin
      if (grant_q == GRANT_WIDTH'(i)) begin
        sel_data  = s_axis_arb_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_keep  = s_axis_arb_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        sel_valid = s_axis_arb_tvalid[i];
        sel_last  = s_axis_arb_tlast[i];
      end
    end
  end

  assign decide = (state_q == ST_IDLE) && w_arb_enable && (|s_axis_arb_tvalid);

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    pkt_done          = 1'b0;
    s_axis_arb_tready = '0;
    m_axis_arb_tdata  = '0;
    m_axis_arb_tkeep  = '0;
    m_axis_arb_tvalid = 1'b0;
    m_axis_arb_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (decide) begin
          grant_d = starve_hit ? starve_idx : prio_idx;
          state_d = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        m_axis_arb_tdata  = sel_data;
        m_axis_arb_tkeep  = sel_keep;
        m_axis_arb_tvalid = sel_valid;
        m_axis_arb_tlast  = sel_last;
        for (int i = 0; i < IF_COUNT_DOWN_RX; i++) begin
          s_axis_arb_tready[i] = (grant_q == GRANT_WIDTH'(i)) && m_axis_arb_tready;
        end
        pkt_done = sel_valid && m_axis_arb_tready && sel_last;
        if (pkt_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Losers with a pending packet age by one per decision; idle queues keep their age.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IF_COUNT_DOWN_RX; i++) age_q[i] <= '0;
    end else if (decide) begin
      for (int i = 0; i < IF_COUNT_DOWN_RX; i++) begin
        if (grant_d == GRANT_WIDTH'(i)) begin
          age_q[i] <= '0;
        end else if (s_axis_arb_tvalid[i] && age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + AGE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_rst_pkt_counter) begin
      for (int i = 0; i < IF_COUNT_DOWN_RX; i++) cnt_q[i] <= '0;
    end else if (pkt_done) begin
      for (int i = 0; i < IF_COUNT_DOWN_RX; i++) begin
        if (grant_q == GRANT_WIDTH'(i)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    w_pkt_counter = '0;
    for (int i = 0; i < IF_COUNT_DOWN_RX; i++) begin
      w_pkt_counter[i*32 +: 32] = cnt_q[i];
    end
  end

  assign w_grant = grant_q;
  assign w_busy  = (state_q == ST_FORWARD);

endmodule

// File: tb/tb_priority_pkt_arbiter.sv
// Directed bench for priority_pkt_arbiter: reset, single packet, strict priority,
// starvation guard, backpressure/gaps, counter-clear collision and mid-packet reset.
module tb_priority_pkt_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int AW = 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   q_data [N];
  logic [KW-1:0]   q_keep [N];
  logic [N-1:0]    q_valid;
  logic [N-1:0]    q_last;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            arb_enable;
  logic [AW-1:0]   starve_limit;
  logic            rst_pkt_counter;
  logic [N*32-1:0] pkt_counter;
  logic [GW-1:0]   grant;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int xfer_base;

  always #5 clk = ~clk;

  assign s_tdata = {q_data[2], q_data[1], q_data[0]};
  assign s_tkeep = {q_keep[2], q_keep[1], q_keep[0]};

  priority_pkt_arbiter #(
    .IF_COUNT_DOWN_RX(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
    .AGE_WIDTH(AW), .GRANT_WIDTH(GW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_arb_tdata(s_tdata), .s_axis_arb_tkeep(s_tkeep),
    .s_axis_arb_tvalid(q_valid), .s_axis_arb_tready(s_tready),
    .s_axis_arb_tlast(q_last),
    .m_axis_arb_tdata(m_tdata), .m_axis_arb_tkeep(m_tkeep),
    .m_axis_arb_tvalid(m_tvalid), .m_axis_arb_tready(m_tready),
    .m_axis_arb_tlast(m_tlast),
    .w_arb_enable(arb_enable), .w_starve_limit(starve_limit),
    .w_rst_pkt_counter(rst_pkt_counter), .w_pkt_counter(pkt_counter),
    .w_grant(grant), .w_busy(busy)
  );

  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready) xfers++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    checks++;
    if (obs !== expd) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int q);
    return pkt_counter[q*32 +: 32];
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  int exp_grant [5] = '{0, 0, 0, 2, 0};
  logic [DW-1:0] qd [N];

  initial begin
    rst = 1'b1;
    q_valid = '0;
    q_last = '0;
    for (int i = 0; i < N; i++) begin
      q_data[i] = '0;
      q_keep[i] = '0;
    end
    m_tready = 1'b1;
    arb_enable = 1'b1;
    starve_limit = '0;
    rst_pkt_counter = 1'b0;
    repeat (3) cyc();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_counters", pkt_counter, 0);
    rst = 1'b0;

    // single 3-beat packet on queue 1
    xfer_base = xfers;
    q_valid[1] = 1'b1; q_data[1] = 64'h1111_0000_0000_0010; q_keep[1] = 8'hFF;
    #1;
    check("t1_bubble_s_tready", s_tready, 0);
    check("t1_bubble_m_tvalid", m_tvalid, 0);
    cyc();
    check("t1_grant", grant, 1);
    check("t1_busy", busy, 1);
    check("t1_beat0", m_tdata, 64'h1111_0000_0000_0010);
    check("t1_s_tready", s_tready, 3'b010);
    cyc();
    q_data[1] = 64'h1111_0000_0000_0011;
    #1;
    check("t1_beat1", m_tdata, 64'h1111_0000_0000_0011);
    cyc();
    q_data[1] = 64'h1111_0000_0000_0012; q_keep[1] = 8'h0F; q_last[1] = 1'b1;
    #1;
    check("t1_beat2", m_tdata, 64'h1111_0000_0000_0012);
    check("t1_last_keep", m_tkeep, 8'h0F);
    check("t1_last_flag", m_tlast, 1);
    cyc();
    q_valid[1] = 1'b0; q_last[1] = 1'b0;
    #1;
    check("t1_idle_after", busy, 0);
    check("t1_m_tvalid_idle", m_tvalid, 0);
    check("t1_counter1", cnt(1), 1);
    check("t1_beats", xfers - xfer_base, 3);

    // strict priority, guard disabled
    pulse_reset();
    qd[0] = 64'hA0A0_A0A0_0000_0000;
    qd[1] = 64'hB0B0_B0B0_0000_0000;
    qd[2] = 64'hC0C0_C0C0_0000_0000;
    q_data[0] = qd[0]; q_keep[0] = 8'hFF; q_last[0] = 1'b1; q_valid[0] = 1'b1;
    q_data[2] = qd[2]; q_keep[2] = 8'hFF; q_last[2] = 1'b1; q_valid[2] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_idle", busy, 0);
      check("t2_q2_ready_idle", s_tready[2], 0);
      cyc();
      check("t2_grant", grant, 0);
      check("t2_q2_ready_fwd", s_tready[2], 0);
      cyc();
    end

    // starvation guard at 3: queue 2 wins the 4th decision
    starve_limit = 8'd3;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t3_grant", grant, exp_grant[k]);
      check("t3_data", m_tdata, qd[exp_grant[k]]);
      cyc();
    end
    q_valid = '0;
    q_last = '0;
    #1;
    check("t3_counter0", cnt(0), 4);
    check("t3_counter2", cnt(2), 1);

    // backpressure and tvalid gaps on a 4-beat queue-1 packet
    starve_limit = '0;
    xfer_base = xfers;
    q_valid[1] = 1'b1; q_data[1] = 64'hB1; q_keep[1] = 8'hFF; q_last[1] = 1'b0;
    cyc();
    check("t4_grant", grant, 1);
    cyc();
    q_data[1] = 64'hB2;
    m_tready = 1'b0;
    q_valid[0] = 1'b1; q_data[0] = 64'hA5; q_last[0] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_bp_data", m_tdata, 64'hB2);
      check("t4_bp_ready", s_tready, 0);
      check("t4_bp_grant", grant, 1);
      cyc();
    end
    m_tready = 1'b1;
    #1;
    check("t4_ready_back", s_tready, 3'b010);
    cyc();
    q_valid[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t4_gap_valid", m_tvalid, 0);
      check("t4_gap_busy", busy, 1);
      check("t4_gap_q0_ready", s_tready[0], 0);
      cyc();
    end
    q_valid[1] = 1'b1; q_data[1] = 64'hB3;
    cyc();
    q_data[1] = 64'hB4; q_last[1] = 1'b1;
    #1;
    check("t4_last_data", m_tdata, 64'hB4);
    cyc();
    q_valid[1] = 1'b0; q_last[1] = 1'b0;
    #1;
    check("t4_idle", busy, 0);
    check("t4_counter1", cnt(1), 1);
    check("t4_beats", xfers - xfer_base, 4);
    cyc();
    check("t4_q0_grant", grant, 0);
    check("t4_q0_data", m_tdata, 64'hA5);
    cyc();
    q_valid[0] = 1'b0;
    #1;
    check("t4_counter0", cnt(0), 5);

    // counter clear collides with a queue-0 tlast transfer
    q_valid[0] = 1'b1;
    cyc();
    rst_pkt_counter = 1'b1;
    #1;
    check("t5_fwd", busy, 1);
    cyc();
    rst_pkt_counter = 1'b0;
    q_valid[0] = 1'b0;
    #1;
    check("t5_counter0_clr", cnt(0), 0);
    check("t5_counter1_clr", cnt(1), 0);
    q_valid[0] = 1'b1;
    cyc();
    cyc();
    q_valid[0] = 1'b0;
    #1;
    check("t5_counter0_next", cnt(0), 1);

    // reset on beat 2 of a 4-beat packet
    q_valid[0] = 1'b1; q_last[0] = 1'b0; q_data[0] = 64'hE0;
    cyc();
    cyc();
    q_data[0] = 64'hE1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q_valid[0] = 1'b0;
    #1;
    check("t6_m_tvalid", m_tvalid, 0);
    check("t6_s_tready", s_tready, 0);
    check("t6_busy", busy, 0);
    check("t6_counters", pkt_counter, 0);
    q_valid[1] = 1'b1; q_data[1] = 64'hF0; q_last[1] = 1'b0;
    cyc();
    check("t6_grant", grant, 1);
    check("t6_data0", m_tdata, 64'hF0);
    cyc();
    q_data[1] = 64'hF1; q_last[1] = 1'b1;
    cyc();
    q_valid[1] = 1'b0; q_last[1] = 1'b0;
    #1;
    check("t6_counter1", cnt(1), 1);
    check("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_pkt_arbiter.md
Name: priority_pkt_arbiter

Overview:
- Packet-granular strict-priority arbiter with an anti-starvation guard; merges the three priority queues of the downstream scheduler into the single TX stream.
- Queue 0 is highest priority, queue 2 lowest.
- A whole packet (first beat through tlast) is granted at a time, so packets are never interleaved.
- Provides per-queue forwarded-packet counters to the AXI-Lite register block.

Parameters:
- IF_COUNT_DOWN_RX, 3, number of input queues (index 0 = highest priority).
- AXIS_DATA_WIDTH, 64, tdata width per stream.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width per stream.
- AGE_WIDTH, 8, width of the per-queue starvation age counter.
- GRANT_WIDTH, $clog2(IF_COUNT_DOWN_RX), width of the grant index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_arb_tdata  in  IF_COUNT_DOWN_RX*AXIS_DATA_WIDTH  queue data; queue i occupies slice [i*W +: W].
- s_axis_arb_tkeep  in  IF_COUNT_DOWN_RX*AXIS_KEEP_WIDTH  queue byte enables.
- s_axis_arb_tvalid  in  IF_COUNT_DOWN_RX  per-queue valid.
- s_axis_arb_tready  out  IF_COUNT_DOWN_RX  per-queue ready.
- s_axis_arb_tlast  in  IF_COUNT_DOWN_RX  per-queue end of packet.
- m_axis_arb_tdata  out  AXIS_DATA_WIDTH  merged data.
- m_axis_arb_tkeep  out  AXIS_KEEP_WIDTH  merged byte enables.
- m_axis_arb_tvalid  out  1  merged valid.
- m_axis_arb_tready  in  1  downstream ready.
- m_axis_arb_tlast  out  1  merged end of packet.
- w_arb_enable  in  1  allows new grants when high.
- w_starve_limit  in  AGE_WIDTH  anti-starvation threshold; 0 disables the guard.
- w_rst_pkt_counter  in  1  clears all packet counters.
- w_pkt_counter  out  IF_COUNT_DOWN_RX*32  forwarded packets per queue; queue i in slice [i*32 +: 32].
- w_grant  out  GRANT_WIDTH  currently or last granted queue.
- w_busy  out  1  high while in FORWARD.

Behaviour:
- Reset values: state IDLE, w_grant=0, w_busy=0, all s_tready=0, m_tvalid=0, m_tdata/m_tkeep/m_tlast=0, all ages=0, all counters=0.
- Reset asserted mid-packet aborts the packet: outputs take reset values on the next edge, and the partial packet is neither counted nor completed.

IDLE:
- Every s_tready is 0 and m_tvalid is 0.
- A grant is decided when w_arb_enable=1 and any s_tvalid=1.
- If w_starve_limit != 0 and some queue i has s_tvalid[i]=1 and age[i] >= w_starve_limit, grant the lowest-index such queue.
- Otherwise grant the lowest-index queue with s_tvalid=1.
- On the grant edge: latch w_grant, move to FORWARD, clear age[grant], and saturating-increment age of every other queue with tvalid=1 (saturates at 2^AGE_WIDTH-1).
- A queue with tvalid=0 during a decision cycle keeps its age.
- No beat transfers in the IDLE cycle: one bubble cycle per packet.

FORWARD:
- Combinational passthrough: m_tdata/tkeep/tlast/tvalid = selected s_* signals of the granted queue.
- s_tready[grant] = m_tready; all other s_tready = 0.
- A beat transfers when m_tvalid && m_tready.
- On a transfer with tlast=1: return to IDLE on the next edge and increment w_pkt_counter[grant].
- The grant is held through tvalid gaps and backpressure; there is no timeout.
- Deasserting w_arb_enable mid-packet does not interrupt it; the block stops granting once back in IDLE.

Counters and outputs:
- Counters wrap modulo 2^32.
- w_rst_pkt_counter=1 clears all counters on the next edge; it wins over a simultaneous increment.
- w_busy = (state == FORWARD).
- w_grant holds its last value while in IDLE.

Test Plan:
- Single-queue packet: only queue 1 sends a 3-beat packet, tkeep last=0x0F, m_tready=1 -> w_grant=1 after 1 bubble cycle, 3 beats out unchanged, w_pkt_counter[1]=1, back in IDLE on the cycle after tlast.
- Strict priority: queues 0 and 2 both valid with a continuous stream, w_starve_limit=0 -> every grant goes to 0 and queue 2 never gets s_tready.
- Anti-starvation: same stimulus with w_starve_limit=3 -> queue 2 granted on the 4th decision (age reaches 3 after 3 losses), then age[2]=0 and queue 0 resumes.
- Backpressure and gaps: hold m_tready=0 for 5 cycles mid-packet, and separately insert 2 tvalid=0 cycles -> no beats dropped or duplicated, grant unchanged, queue 0 arriving meanwhile waits until after tlast.
- Counter reset collision: w_rst_pkt_counter pulsed on the same edge as a tlast transfer on queue 0 -> w_pkt_counter[0]=0 afterwards; the next packet gives 1.
- Reset mid-packet: rst on beat 2 of 4 -> next cycle m_tvalid=0, s_tready=0, state IDLE, counters 0; a fresh packet after reset forwards normally.
